// File: rtl/pc_select_unit_pkg.sv
// Shared fetch definitions: pc_src codes,
// next-PC state encoding and redirect ranking.
package pc_select_unit_pkg;

  localparam logic [1:0] SRC_SEQ  = 2'd0;
  localparam logic [1:0] SRC_BR   = 2'd1;
  localparam logic [1:0] SRC_JMP  = 2'd2;
  localparam logic [1:0] SRC_TRAP = 2'd3;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic logic [1:0] src_rank(
    input logic [1:0] code
  );
    logic [1:0] r;
    r = 2'd0;
    unique case (code)
      SRC_TRAP: r = 2'd3;
      SRC_JMP:  r = 2'd2;
      SRC_BR:   r = 2'd1;
      default:  r = 2'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pc_select_unit_if.sv
// Fetch-side bundle: redirect requests in,
// fetch PC and status out.
interface pc_select_unit_if #(
  parameter int PC_W = 10
);
  logic            freeze;
  logic            fetch_ready;
  logic            br_taken;
  logic [PC_W-1:0] br_target;
  logic            jmp_valid;
  logic [PC_W-1:0] jmp_target;
  logic            trap_valid;
  logic [PC_W-1:0] pc;
  logic            pc_valid;
  logic [1:0]      pc_src;
  logic            flush;
  logic            redirect_pending;

  modport master (
    output freeze, fetch_ready,
    output br_taken, br_target,
    output jmp_valid, jmp_target,
    output trap_valid,
    input  pc, pc_valid, pc_src,
    input  flush, redirect_pending
  );

  modport slave (
    input  freeze, fetch_ready,
    input  br_taken, br_target,
    input  jmp_valid, jmp_target,
    input  trap_valid,
    output pc, pc_valid, pc_src,
    output flush, redirect_pending
  );
endinterface

// File: rtl/pc_select_unit_redirect_arb.sv
// Two-way redirect arbiter; on equal rank
// the a-side wins.
module pc_redirect_arb
  import pc_select_unit_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic            a_valid,
  input  logic [1:0]      a_code,
  input  logic [PC_W-1:0] a_target,
  input  logic            b_valid,
  input  logic [1:0]      b_code,
  input  logic [PC_W-1:0] b_target,
  output logic            valid,
  output logic [1:0]      code,
  output logic [PC_W-1:0] target
);

  logic pick_a;

  always_comb begin
    pick_a = a_valid && (!b_valid ||
      src_rank(a_code) >= src_rank(b_code));
    valid  = a_valid || b_valid;
    code   = pick_a ? a_code : b_code;
    target = pick_a ? a_target : b_target;
  end

endmodule

// File: rtl/pc_select_unit.sv
// Fetch PC register with fixed-priority next-PC
// selection and redirects deferred across freezes.
module pc_select_unit
  import pc_select_unit_pkg::*;
#(
  parameter int              PC_W     = 10,
  parameter int              PC_STEP  = 1,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(0),
  parameter logic [PC_W-1:0] TRAP_PC  = PC_W'(10'h3F0)
) (
  input logic           clk,
  input logic           rst,
  pc_select_unit_if.slave bus
);

  state_t          state;
  logic [PC_W-1:0] pc_q;
  logic            valid_q;
  logic [1:0]      src_q;
  logic            flush_q;
  logic            pend_v;
  logic [1:0]      pend_code;
  logic [PC_W-1:0] pend_tgt;

  logic            jb_v, req_v, mrg_v;
  logic [1:0]      jb_c, req_c, mrg_c;
  logic [PC_W-1:0] jb_t, req_t, mrg_t;

  pc_redirect_arb #(.PC_W(PC_W)) u_jb (
    .a_valid (bus.jmp_valid),
    .a_code  (SRC_JMP),
    .a_target(bus.jmp_target),
    .b_valid (bus.br_taken),
    .b_code  (SRC_BR),
    .b_target(bus.br_target),
    .valid   (jb_v),
    .code    (jb_c),
    .target  (jb_t)
  );

  pc_redirect_arb #(.PC_W(PC_W)) u_req (
    .a_valid (bus.trap_valid),
    .a_code  (SRC_TRAP),
    .a_target(TRAP_PC),
    .b_valid (jb_v),
    .b_code  (jb_c),
    .b_target(jb_t),
    .valid   (req_v),
    .code    (req_c),
    .target  (req_t)
  );

  // Fresh request on the a-side: it wins ties
  // against whatever is already pending.
  pc_redirect_arb #(.PC_W(PC_W)) u_mrg (
    .a_valid (req_v),
    .a_code  (req_c),
    .a_target(req_t),
    .b_valid (pend_v),
    .b_code  (pend_code),
    .b_target(pend_tgt),
    .valid   (mrg_v),
    .code    (mrg_c),
    .target  (mrg_t)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= BOOT;
      pc_q      <= RESET_PC;
      valid_q   <= 1'b0;
      src_q     <= SRC_SEQ;
      flush_q   <= 1'b0;
      pend_v    <= 1'b0;
      pend_code <= SRC_SEQ;
      pend_tgt  <= '0;
    end else begin
      flush_q <= 1'b0;
      unique case (state)
        BOOT: begin
          state   <= RUN;
          valid_q <= 1'b1;
        end
        default: begin
          if (bus.freeze) begin
            state <= HOLD;
            if (mrg_v) begin
              pend_v    <= 1'b1;
              pend_code <= mrg_c;
              pend_tgt  <= mrg_t;
            end
          end else begin
            state  <= RUN;
            pend_v <= 1'b0;
            if (mrg_v) begin
              pc_q    <= mrg_t;
              src_q   <= mrg_c;
              flush_q <= 1'b1;
            end else if (valid_q &&
                         bus.fetch_ready) begin
              pc_q  <= pc_q + PC_W'(PC_STEP);
              src_q <= SRC_SEQ;
            end
          end
        end
      endcase
    end
  end

  assign bus.pc               = pc_q;
  assign bus.pc_valid         = valid_q;
  assign bus.pc_src           = src_q;
  assign bus.flush            = flush_q;
  assign bus.redirect_pending = pend_v;

endmodule

// File: tb/tb_pc_select_unit.sv
// Directed scoreboard bench for pc_select_unit:
// driver queues expectations, monitor checks them.
module tb_pc_select_unit;

  typedef struct packed {
    logic [9:0] pc;
    logic       v;
    logic [1:0] src;
    logic       f;
    logic       p;
  } exp_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  exp_t q[$];

  pc_select_unit_if #(.PC_W(10)) bus ();

  pc_select_unit #(
    .PC_W    (10),
    .PC_STEP (1),
    .RESET_PC(10'h000),
    .TRAP_PC (10'h3F0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t act();
    exp_t a;
    a.pc  = bus.pc;
    a.v   = bus.pc_valid;
    a.src = bus.pc_src;
    a.f   = bus.flush;
    a.p   = bus.redirect_pending;
    return a;
  endfunction

  task automatic check(string nm, exp_t e);
    exp_t a;
    a = act();
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got pc=%h v=%b src=%0d f=%b p=%b, want pc=%h v=%b src=%0d f=%b p=%b",
        nm, a.pc, a.v, a.src, a.f, a.p,
        e.pc, e.v, e.src, e.f, e.p);
    end
  endtask

  // Monitor: compare at each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() != 0) check("cycle", q.pop_front());
    end
  end

  task automatic step(
    input logic fr, input logic frz,
    input logic br, input logic [9:0] bt,
    input logic jv, input logic [9:0] jt,
    input logic tv,
    input logic [9:0] epc, input logic ev,
    input logic [1:0] es, input logic ef,
    input logic ep
  );
    bus.fetch_ready = fr;
    bus.freeze      = frz;
    bus.br_taken    = br;
    bus.br_target   = bt;
    bus.jmp_valid   = jv;
    bus.jmp_target  = jt;
    bus.trap_valid  = tv;
    q.push_back('{epc, ev, es, ef, ep});
    @(negedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.fetch_ready = 1'b0;
    bus.freeze      = 1'b0;
    bus.br_taken    = 1'b0;
    bus.br_target   = '0;
    bus.jmp_valid   = 1'b0;
    bus.jmp_target  = '0;
    bus.trap_valid  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset", '{10'h000, 1'b0, 2'd0, 1'b0, 1'b0});
    rst = 1'b0;

    // boot and sequential fetch
    step(1,0, 0,0, 0,0, 0, 10'h000,1,0,0,0);
    step(1,0, 0,0, 0,0, 0, 10'h001,1,0,0,0);
    step(1,0, 0,0, 0,0, 0, 10'h002,1,0,0,0);
    step(1,0, 0,0, 0,0, 0, 10'h003,1,0,0,0);
    // wrap-around after jump
    step(1,0, 0,0, 1,10'h3FE, 0, 10'h3FE,1,2,1,0);
    step(1,0, 0,0, 0,0, 0, 10'h3FF,1,0,0,0);
    step(1,0, 0,0, 0,0, 0, 10'h000,1,0,0,0);
    step(1,0, 0,0, 0,0, 0, 10'h001,1,0,0,0);
    // simultaneous requests
    step(1,0, 1,10'h020, 1,10'h040, 1,
         10'h3F0,1,3,1,0);
    step(1,0, 1,10'h020, 1,10'h040, 0,
         10'h040,1,2,1,0);
    // back-pressure
    step(1,0, 0,0, 1,10'h005, 0, 10'h005,1,2,1,0);
    step(0,0, 0,0, 0,0, 0, 10'h005,1,2,0,0);
    step(0,0, 0,0, 0,0, 0, 10'h005,1,2,0,0);
    step(0,0, 0,0, 0,0, 0, 10'h005,1,2,0,0);
    step(0,0, 1,10'h100, 0,0, 0, 10'h100,1,1,1,0);
    // deferred redirect across freeze
    step(1,0, 0,0, 1,10'h008, 0, 10'h008,1,2,1,0);
    step(1,1, 1,10'h050, 0,0, 0, 10'h008,1,2,0,1);
    step(1,1, 0,0, 1,10'h060, 0, 10'h008,1,2,0,1);
    step(1,1, 1,10'h070, 0,0, 0, 10'h008,1,2,0,1);
    step(1,0, 0,0, 0,0, 0, 10'h060,1,2,1,0);
    step(1,0, 0,0, 0,0, 0, 10'h061,1,0,0,0);
    // release: lower fresh loses to pending
    step(1,1, 0,0, 1,10'h200, 0, 10'h061,1,0,0,1);
    step(1,0, 1,10'h300, 0,0, 0, 10'h200,1,2,1,0);
    // release: equal-rank fresh wins
    step(1,1, 0,0, 1,10'h220, 0, 10'h200,1,2,0,1);
    step(1,0, 0,0, 1,10'h230, 0, 10'h230,1,2,1,0);
    // pending trap, then async reset mid-freeze
    step(1,1, 0,0, 0,0, 1, 10'h230,1,2,0,1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", '{10'h000,1'b0,2'd0,1'b0,1'b0});
    bus.freeze     = 1'b0;
    bus.trap_valid = 1'b0;

    for (int i = 0; i < 10 && q.size() != 0; i++)
      @(negedge clk);
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d left, want 0",
        q.size());
    end
    $display("[TB] %0d tests run, %0d failed",
      tests, fails);
    $finish;
  end

endmodule
